matrix_keypad_scanner: RTL and testbench
========================================

# matrix_keypad_scanner

- Input-side counterpart of the 8x8 LED matrix display driver: it drives the column lines of a 4x4 key matrix and reads back its row lines.
- Debounces one key and reports its 4-bit code with a one-cycle strobe.
- Sits beside the sequence generator: `key_valid` can stand in for the filtered button as the generator's enable, and `key_code` supplies a value.
- The scan rate comes from the existing clock divider through `CE`.

## Interface

- `DEBOUNCE_SCANS`, default 4: consecutive confirming `CE` samples required for press and for release; legal range 1..15.
- `REPEAT_SCANS`, default 64: `CE` samples between auto-repeat strobes; used only with `KEYPAD_AUTOREPEAT_EN`; legal range 1..255.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `CE` in 1: scan-step enable, a one-`clk` pulse from the divider; may be held high.
- `row_in` in 4: key rows, active-low (pulled up externally), asynchronous.
- `column` out 4: column drive, active-low, exactly one bit low at all times.
- `key_code` out 4: code of the last accepted key, `{row_idx[1:0], col_idx[1:0]}`.
- `key_valid` out 1: one-`clk` strobe when a press is accepted (and on repeat).
- `key_pressed` out 1: high while an accepted key is held.

## Operation

**Input synchronisation**
- `row_in` passes through a 2-flop synchroniser, giving `row_s`; all decisions use `row_s`.
- A key is "down" when its `row_s` bit is 0.
- Nothing advances unless `CE` is high.

**Registers**
- `cidx` (2 bits): active column; `column = ~(4'b0001 << cidx)`.
- `ridx` (2 bits): latched row.
- `cnt`: debounce/repeat counter, 8 bits.

**FSM states:** SCAN, DEBOUNCE, HELD, RELEASE.

- **SCAN**, on `CE`:
  - If any `row_s` bit is 0: latch `ridx` (lowest-numbered low row wins), `cnt <= 0`, go to DEBOUNCE; `cidx` is held.
  - Otherwise: `cidx <= cidx + 1`, wrapping 3 -> 0.
- **DEBOUNCE**, on `CE`:
  - If `row_s[ridx] == 0`: `cnt <= cnt + 1`.
  - When the incremented value equals `DEBOUNCE_SCANS`:
    - `key_code <= {ridx, cidx}`;
    - `key_valid <= 1` for one cycle;
    - `key_pressed <= 1`;
    - `cnt <= 0`;
    - go to HELD.
  - If `row_s[ridx] == 1`: treat as a bounce; advance `cidx` and go to SCAN with no output.
- **HELD**, on `CE`:
  - If `row_s[ridx] == 1`: `cnt <= 1`, go to RELEASE.
  - Otherwise stay in HELD; `cnt` is used only for auto-repeat.
- **RELEASE**, on `CE`:
  - If `row_s[ridx] == 1`: `cnt <= cnt + 1`.
  - Reaching `DEBOUNCE_SCANS` (or already at it when `DEBOUNCE_SCANS == 1`) does all of:
    - `key_pressed <= 0`;
    - `cidx <= cidx + 1`;
    - go to SCAN.
  - If `row_s[ridx] == 0`: `cnt <= 0`, go back to HELD, with no new strobe.

**Locked column and multi-key behaviour**
- Outside SCAN, `column` stays on the latched `cidx`.
- Other keys are ignored until the FSM returns to SCAN.
- `key_code` holds its value until the next accepted press.

## Timing

**Reset values:**
- state SCAN, `cidx = 0`, so `column = 4'b1110`;
- `key_code = 4'h0`;
- `key_valid = 0`, `key_pressed = 0`;
- `cnt = 0`.

**Latency:**
- A row change reaches `row_s` 2 `clk` edges later.
- `key_valid` and `key_pressed` are registered. They rise on the edge of the `CE` that completes debounce, and are visible in the following cycle.
- A press is accepted after 1 detection `CE` plus `DEBOUNCE_SCANS` confirming `CE`s.

**Strobe and output behaviour:**
- `key_valid` is exactly one `clk` wide regardless of `CE` duty.
- `column` changes only on `CE` edges, or on reset.

**Reset and enable corner cases:**
- `rst` asserted mid-operation returns to the reset values on the next edge; no `key_valid` is emitted.
- `rst` has priority over `CE`.
- With `CE` held high, every `clk` is a scan step; this is legal and behaves identically, just faster.

## Configuration

`KEYPAD_AUTOREPEAT_EN`
- **Defined:** in HELD, `cnt` increments on each `CE` while the key stays down. When it reaches `REPEAT_SCANS`:
  - `key_valid` pulses again with an unchanged `key_code`;
  - `cnt` resets to 0.
  - Entering RELEASE or SCAN stops the repeat.
- **Undefined:** exactly one `key_valid` per accepted press; `REPEAT_SCANS` is ignored.

## Test plan

- **Reset:** reset held 3 cycles with `row_in = 4'hF` -> `column = 4'b1110`, `key_code = 0`, `key_valid = 0`, `key_pressed = 0`.
- **Idle scan:** `CE` every 4 clks, no key -> `column` sequence 1110, 1101, 1011, 0111, 1110; `key_valid` never high.
- **Press/release:** `DEBOUNCE_SCANS = 4`, key row 2 / col 1 held clean. Drive `row_in = 4'b1011` only while `column = 4'b1101`; otherwise keep `row_in` high.
  - Press: after 5 `CE`s from detection, exactly one `key_valid` with `key_code = 4'h9`, and `key_pressed = 1`.
  - Release: after release, 4 `CE`s of high -> `key_pressed = 0` and scanning resumes at column 2.
- **Bounce:** row low for 2 `CE`s, high for 1 `CE`, low again -> no `key_valid` from the first burst. Detection restarts from SCAN when that key's column is next scanned.
- **Two keys:** rows 0 and 3 both low on the same column 2 -> `key_code = 4'h2`. Row 3 is ignored until release completes.
- **Auto-repeat / reset mid-press:**
  - With `KEYPAD_AUTOREPEAT_EN`, `REPEAT_SCANS = 8`, key held 30 `CE`s past acceptance -> `key_valid` count 1 + 3.
  - `rst` asserted in DEBOUNCE -> no strobe, `column = 4'b1110`.

Source files
------------

// File: rtl/matrix_keypad_scanner.sv
// Scans a 4x4 active-low key matrix one column at a time, debounces a single key
// and strobes its {row,col} code. Define KEYPAD_AUTOREPEAT_EN for repeat strobes while held.
module matrix_keypad_scanner #(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       CE,
  input  logic [3:0] row_in,
  output logic [3:0] column,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam logic [7:0] DB_N = 8'(DEBOUNCE_SCANS);
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [7:0] RP_N = 8'(REPEAT_SCANS);
`endif

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t     state_q;
  logic [3:0] row_m_q, row_s_q;
  logic [1:0] cidx_q, ridx_q;
  logic [7:0] cnt_q;
  logic [3:0] key_code_q;
  logic       key_valid_q, key_pressed_q;

  logic [1:0] low_row;
  logic       any_down, sel_up;
  logic [7:0] cnt_inc;

  // Lowest-numbered active row wins when several keys share the column.
  always_comb begin
    low_row = 2'd3;
    if      (!row_s_q[0]) low_row = 2'd0;
    else if (!row_s_q[1]) low_row = 2'd1;
    else if (!row_s_q[2]) low_row = 2'd2;
  end

  assign any_down = ~&row_s_q;
  assign sel_up   = row_s_q[ridx_q];
  assign cnt_inc  = cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SCAN;
      row_m_q       <= 4'hF;
      row_s_q       <= 4'hF;
      cidx_q        <= 2'd0;
      ridx_q        <= 2'd0;
      cnt_q         <= 8'd0;
      key_code_q    <= 4'h0;
      key_valid_q   <= 1'b0;
      key_pressed_q <= 1'b0;
    end else begin
      row_m_q     <= row_in;
      row_s_q     <= row_m_q;
      key_valid_q <= 1'b0;
      if (CE) begin
        unique case (state_q)
          SCAN: begin
            if (any_down) begin
              ridx_q  <= low_row;
              cnt_q   <= 8'd0;
              state_q <= DEBOUNCE;
            end else begin
              cidx_q <= cidx_q + 2'd1;
            end
          end
          DEBOUNCE: begin
            if (!sel_up) begin
              if (cnt_inc == DB_N) begin
                key_code_q    <= {ridx_q, cidx_q};
                key_valid_q   <= 1'b1;
                key_pressed_q <= 1'b1;
                cnt_q         <= 8'd0;
                state_q       <= HELD;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              // Bounce: give up on this column and keep scanning.
              cidx_q  <= cidx_q + 2'd1;
              state_q <= SCAN;
            end
          end
          HELD: begin
            if (sel_up) begin
              cnt_q   <= 8'd1;
              state_q <= RELEASE;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            else if (cnt_inc == RP_N) begin
              key_valid_q <= 1'b1;
              cnt_q       <= 8'd0;
            end else begin
              cnt_q <= cnt_inc;
            end
`endif
          end
          RELEASE: begin
            if (sel_up) begin
              cnt_q <= cnt_inc;
              // >= also covers DEBOUNCE_SCANS == 1, where cnt already sits at the limit.
              if (cnt_inc >= DB_N) begin
                key_pressed_q <= 1'b0;
                cidx_q        <= cidx_q + 2'd1;
                state_q       <= SCAN;
              end
            end else begin
              cnt_q   <= 8'd0;
              state_q <= HELD;
            end
          end
        endcase
      end
    end
  end

  assign column      = ~(4'b0001 << cidx_q);
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_pressed = key_pressed_q;

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Bench for matrix_keypad_scanner: a physical key-matrix model drives row_in, and a
// scan-step reference model predicts column/key outputs every cycle.
module tb_matrix_keypad_scanner;

  localparam int DB  = 4;
  localparam int REP = 8;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  localparam int P_IDLE = 0, P_CONF = 1, P_HOLD = 2, P_REL = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       CE  = 1'b0;
  logic [3:0] row_in, column, key_code;
  logic       key_valid, key_pressed;

  logic [3:0][3:0] key_down = '0;  // [row][col], 1 = key physically down

  int n_chk = 0, n_err = 0, n_valid = 0;
  bit chk_on = 1'b0;

  matrix_keypad_scanner #(.DEBOUNCE_SCANS(DB), .REPEAT_SCANS(REP)) dut (
    .clk(clk), .rst(rst), .CE(CE), .row_in(row_in), .column(column),
    .key_code(key_code), .key_valid(key_valid), .key_pressed(key_pressed)
  );

  always #5 clk = ~clk;

  // A row reads low when a down key sits on the currently driven column.
  for (genvar r = 0; r < 4; r++) begin : g_row
    assign row_in[r] = ~|(key_down[r] & ~column);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one scan step per CE, rows seen through a two-sample delay.
  int         m_cidx, m_ridx, m_cnt, m_ph;
  logic [3:0] m_meta, m_s, m_code, m_col;
  bit         m_valid, m_pressed;

  function automatic logic [3:0] rows_at(int c);
    logic [3:0] v;
    for (int r = 0; r < 4; r++) v[r] = ~key_down[r][c];
    return v;
  endfunction

  always @(posedge clk) begin
    logic [3:0] seen;
    if (rst) begin
      m_meta = 4'hF; m_s = 4'hF; m_cidx = 0; m_ridx = 0; m_cnt = 0;
      m_ph = P_IDLE; m_code = 4'h0; m_valid = 1'b0; m_pressed = 1'b0;
    end else begin
      seen    = rows_at(m_cidx);
      m_valid = 1'b0;
      if (CE) begin
        case (m_ph)
          P_IDLE:
            if (m_s != 4'hF) begin
              for (int r = 3; r >= 0; r--) if (!m_s[r]) m_ridx = r;
              m_cnt = 0; m_ph = P_CONF;
            end else m_cidx = (m_cidx + 1) % 4;
          P_CONF:
            if (!m_s[m_ridx]) begin
              m_cnt++;
              if (m_cnt == DB) begin
                m_code = 4'(m_ridx * 4 + m_cidx);
                m_valid = 1'b1; m_pressed = 1'b1; m_cnt = 0; m_ph = P_HOLD;
              end
            end else begin
              m_cidx = (m_cidx + 1) % 4; m_ph = P_IDLE;
            end
          P_HOLD:
            if (m_s[m_ridx]) begin
              m_cnt = 1; m_ph = P_REL;
            end else if (AR) begin
              m_cnt++;
              if (m_cnt == REP) begin m_valid = 1'b1; m_cnt = 0; end
            end
          default:
            if (m_s[m_ridx]) begin
              m_cnt++;
              if (m_cnt >= DB) begin
                m_pressed = 1'b0; m_cidx = (m_cidx + 1) % 4; m_ph = P_IDLE;
              end
            end else begin
              m_cnt = 0; m_ph = P_HOLD;
            end
        endcase
      end
      m_s    = m_meta;
      m_meta = seen;
    end
  end

  always @(posedge clk) if (key_valid === 1'b1) n_valid++;

  always @(negedge clk) if (chk_on) begin
    m_col = 4'hF;
    m_col[m_cidx] = 1'b0;
    chk("column", column, m_col);
    chk("key_code", key_code, m_code);
    chk("key_valid", key_valid, m_valid);
    chk("key_pressed", key_pressed, m_pressed);
  end

  task automatic pulse(input int n);
    repeat (n) begin
      @(negedge clk); CE = 1'b1;
      @(negedge clk); CE = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [3:0] seq [4];
    int v0, mode, left;
    bit hit;
    seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // Reset
    @(negedge clk); chk_on = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_column", column, 4'b1110);
    chk("rst_code", key_code, 4'h0);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_pressed", key_pressed, 1'b0);
    rst = 1'b0;

    // Idle scan
    for (int i = 0; i < 4; i++) begin
      pulse(1);
      chk("idle_column", column, seq[i]);
    end
    chk("idle_strobes", n_valid, 0);

    // Press row 2 / col 1 and hold 30 scans past acceptance
    v0 = n_valid;
    key_down[2][1] = 1'b1; settle();
    pulse(36);
    chk("press_strobes", n_valid - v0, AR ? 4 : 1);
    chk("press_code", key_code, 4'h9);
    chk("press_held", key_pressed, 1'b1);

    // Release: four high scans, then scanning resumes on column 2
    key_down[2][1] = 1'b0; settle();
    pulse(4);
    chk("rel_pressed", key_pressed, 1'b0);
    chk("rel_column", column, 4'b1011);
    chk("rel_strobes", n_valid - v0, AR ? 4 : 1);

    // Two keys on column 2: row 0 wins, row 3 ignored
    v0 = n_valid;
    key_down[0][2] = 1'b1; key_down[3][2] = 1'b1; settle();
    pulse(8);
    chk("two_code", key_code, 4'h2);
    chk("two_held", key_pressed, 1'b1);
    key_down[0][2] = 1'b0; settle();
    pulse(4);
    chk("two_rel", key_pressed, 1'b0);
    key_down[3][2] = 1'b0; settle();
    pulse(8);
    chk("two_strobes", n_valid - v0, 1);

    // Reset while confirming a press
    key_down[1][3] = 1'b1; settle();
    hit = 1'b0;
    for (int i = 0; i < 16 && !hit; i++) begin
      pulse(1);
      hit = (m_ph == P_CONF);
    end
    chk("reach_debounce", hit, 1'b1);
    v0 = n_valid;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; key_down = '0;
    chk("rstmid_column", column, 4'b1110);
    chk("rstmid_valid", key_valid, 1'b0);
    chk("rstmid_pressed", key_pressed, 1'b0);
    pulse(8);
    chk("rstmid_strobes", n_valid - v0, 0);

    // Random keys, CE duty and occasional reset against the model
    mode = 0; left = 0;
    for (int i = 0; i < 3000; i++) begin
      int r, c;
      @(negedge clk);
      if (left == 0) begin mode = $urandom_range(0, 2); left = $urandom_range(20, 200); end
      left--;
      case (mode)
        0:       CE = (i % 4 == 0);
        1:       CE = 1'b1;
        default: CE = ($urandom_range(0, 2) == 0);
      endcase
      if ($urandom_range(0, 24) == 0) begin
        r = $urandom_range(0, 3); c = $urandom_range(0, 3);
        key_down[r][c] = ~key_down[r][c];
      end
      if ($countones(key_down) > 3) key_down = '0;
      rst = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk); CE = 1'b0; rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
